// File: rtl/psum_pkg.sv
// Shared types and helpers for the PE-array requantisation output stage.
// Optional bias feature is enabled with the PSUM_BIAS_EN macro.
package psum_pkg;

  localparam int SHIFT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_QUANT,
    ST_OUTPUT
  } state_e;

  function automatic longint sat_max(int dw);
    return (longint'(1) <<< (dw - 1)) - 1;
  endfunction

  function automatic longint sat_min(int dw);
    return -(longint'(1) <<< (dw - 1));
  endfunction

endpackage

// File: rtl/psum_requant_lane.sv
// Combinational round / arithmetic shift / saturate for one column lane.
// With PSUM_BIAS_EN a per-lane bias is added ahead of rounding.
module psum_requant_lane
  import psum_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic [ACC_WIDTH-1:0]  acc_i,
`ifdef PSUM_BIAS_EN
  input  logic [ACC_WIDTH-1:0]  bias_i,
`endif
  input  logic [SHIFT_W-1:0]    shift_i,
  output logic [DATA_WIDTH-1:0] q_o
);

  localparam int RW = ACC_WIDTH + 1;
  localparam logic signed [RW-1:0] MAXV = RW'(sat_max(DATA_WIDTH));
  localparam logic signed [RW-1:0] MINV = RW'(sat_min(DATA_WIDTH));

  logic signed [RW-1:0] sum;
  logic signed [RW-1:0] rnd;
  logic signed [RW-1:0] r;
  logic signed [RW-1:0] q;

  always_comb begin
    sum = {acc_i[ACC_WIDTH-1], acc_i};
`ifdef PSUM_BIAS_EN
    sum = sum + {bias_i[ACC_WIDTH-1], bias_i};
`endif
    rnd = '0;
    if (shift_i != '0) begin
      rnd = RW'(1) << (shift_i - SHIFT_W'(1));
    end
    r = sum + rnd;
    q = r >>> shift_i;
    if (q > MAXV) begin
      q_o = MAXV[DATA_WIDTH-1:0];
    end else if (q < MINV) begin
      q_o = MINV[DATA_WIDTH-1:0];
    end else begin
      q_o = q[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/psum_requant.sv
// Accumulates PE-array partial sums over K tiles, then requantises per column.
// Define PSUM_BIAS_EN to add the bias_in port and per-lane bias.
module psum_requant
  import psum_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int PE_OUT_WIDTH = 21,
  parameter int ACC_WIDTH    = 32,
  parameter int NUM_COLS     = 4,
  parameter int TILE_W       = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [TILE_W-1:0]                num_tiles,
  input  logic [SHIFT_W-1:0]               shift,
  input  logic                             acc_valid,
  input  logic [NUM_COLS*PE_OUT_WIDTH-1:0] acc_in,
`ifdef PSUM_BIAS_EN
  input  logic [NUM_COLS*ACC_WIDTH-1:0]    bias_in,
`endif
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_COLS*DATA_WIDTH-1:0]   out_data,
  output logic                             busy,
  output logic                             drop
);

  state_e state_q, state_d;
  logic [TILE_W-1:0] cnt_q, cnt_d;
  logic [TILE_W-1:0] tiles_q, tiles_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic drop_q, drop_d;
  logic [NUM_COLS-1:0][ACC_WIDTH-1:0] acc_q, acc_d;
  logic [NUM_COLS-1:0][ACC_WIDTH-1:0] ext;
  logic [NUM_COLS-1:0][DATA_WIDTH-1:0] out_q, out_d;
  logic [NUM_COLS-1:0][DATA_WIDTH-1:0] lane_q;
`ifdef PSUM_BIAS_EN
  logic [NUM_COLS-1:0][ACC_WIDTH-1:0] bias_q, bias_d;
`endif

  for (genvar g = 0; g < NUM_COLS; g++) begin : g_lane
    localparam int LO = g * PE_OUT_WIDTH;
    localparam int HI = LO + PE_OUT_WIDTH - 1;

    assign ext[g] = {{(ACC_WIDTH-PE_OUT_WIDTH){acc_in[HI]}},
                     acc_in[LO +: PE_OUT_WIDTH]};

    psum_requant_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
    ) u_lane (
      .acc_i   (acc_q[g]),
`ifdef PSUM_BIAS_EN
      .bias_i  (bias_q[g]),
`endif
      .shift_i (shift_q),
      .q_o     (lane_q[g])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tiles_d = tiles_q;
    shift_d = shift_q;
    drop_d  = drop_q;
    acc_d   = acc_q;
    out_d   = out_q;
`ifdef PSUM_BIAS_EN
    bias_d  = bias_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (acc_valid) drop_d = 1'b1;
        if (start) begin
          tiles_d = (num_tiles == '0) ? TILE_W'(1) : num_tiles;
          shift_d = shift;
          drop_d  = acc_valid;
          cnt_d   = '0;
`ifdef PSUM_BIAS_EN
          bias_d  = bias_in;
`endif
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (acc_valid) begin
          // first beat loads, so no clear cycle between jobs
          for (int i = 0; i < NUM_COLS; i++) begin
            acc_d[i] = (cnt_q == '0) ? ext[i] : acc_q[i] + ext[i];
          end
          cnt_d = cnt_q + TILE_W'(1);
          if (cnt_q == tiles_q - TILE_W'(1)) state_d = ST_QUANT;
        end
      end
      ST_QUANT: begin
        if (acc_valid) drop_d = 1'b1;
        out_d   = lane_q;
        state_d = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (acc_valid) drop_d = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tiles_q <= '0;
      shift_q <= '0;
      drop_q  <= 1'b0;
      acc_q   <= '0;
      out_q   <= '0;
`ifdef PSUM_BIAS_EN
      bias_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tiles_q <= tiles_d;
      shift_q <= shift_d;
      drop_q  <= drop_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
`ifdef PSUM_BIAS_EN
      bias_q  <= bias_d;
`endif
    end
  end

  assign out_valid = (state_q == ST_OUTPUT);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = out_q;
  assign drop      = drop_q;

endmodule

// File: tb/tb_psum_requant.sv
// Directed scoreboard bench for psum_requant (default parameters).
// Bias cases are compiled in when PSUM_BIAS_EN is defined.
module tb_psum_requant;

  localparam int DW = 8;
  localparam int PW = 21;
  localparam int AW = 32;
  localparam int NC = 4;
  localparam int TW = 8;

  typedef logic [NC*DW-1:0] out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [TW-1:0] num_tiles = '0;
  logic [4:0] shift = '0;
  logic acc_valid = 1'b0;
  logic [NC*PW-1:0] acc_in = '0;
`ifdef PSUM_BIAS_EN
  logic [NC*AW-1:0] bias_in = '0;
`endif
  logic out_valid;
  logic out_ready = 1'b0;
  out_t out_data;
  logic busy;
  logic drop;

  int vectors = 0;
  int miscompares = 0;
  out_t sb[$];

  always #5 clk = ~clk;

  psum_requant dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_tiles (num_tiles),
    .shift     (shift),
    .acc_valid (acc_valid),
    .acc_in    (acc_in),
`ifdef PSUM_BIAS_EN
    .bias_in   (bias_in),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .drop      (drop)
  );

  function automatic logic [NC*PW-1:0] pk_in(int a, int b, int c, int d);
    return {21'(d), 21'(c), 21'(b), 21'(a)};
  endfunction

  function automatic out_t pk_out(int a, int b, int c, int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(int nt, int sh);
    start = 1'b1;
    num_tiles = TW'(nt);
    shift = 5'(sh);
    @(negedge clk);
    start = 1'b0;
    acc_valid = 1'b0;
    acc_in = '0;
  endtask

  task automatic beat(logic [NC*PW-1:0] v);
    acc_valid = 1'b1;
    acc_in = v;
    @(negedge clk);
    acc_valid = 1'b0;
    acc_in = '0;
  endtask

  task automatic wait_valid(string tag);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    check(tag, out_valid, 1'b1);
  endtask

  task automatic pop_check(string tag);
    out_t e;
    e = (sb.size() != 0) ? sb.pop_front() : 'x;
    check(tag, out_data, e);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_ovld"}, out_valid, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ovld", out_valid, 1'b0);
    check("rst_data", out_data, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_drop", drop, 1'b0);

    // saturation, latency two edges after the beat
    sb.push_back(pk_out(100, 127, -128, -5));
    start_job(1, 0);
    check("sat_busy", busy, 1'b1);
    beat(pk_in(100, 200, -300, -5));
    check("sat_early", out_valid, 1'b0);
    @(negedge clk);
    check("sat_ovld", out_valid, 1'b1);
    pop_check("sat_data");

    // zero tiles, beat alongside start is dropped, out_ready pre-held
    sb.push_back(pk_out(9, 0, 0, 0));
    out_ready = 1'b1;
    acc_valid = 1'b1;
    acc_in = pk_in(50, 50, 50, 50);
    start_job(0, 0);
    check("zt_drop", drop, 1'b1);
    beat(pk_in(9, 0, 0, 0));
    check("zt_early", out_valid, 1'b0);
    check("zt_busy", busy, 1'b1);
    @(negedge clk);
    check("zt_ovld", out_valid, 1'b1);
    pop_check("zt_data");

    // multi-tile rounding
    sb.push_back(pk_out(8, -1, 127, -128));
    start_job(3, 2);
    check("mt_dropclr", drop, 1'b0);
    beat(pk_in(10, -2, 1000, -1000));
    beat(pk_in(11, -2, 1000, -1000));
    check("mt_noval", out_valid, 1'b0);
    beat(pk_in(12, -2, 1000, -1000));
    wait_valid("mt_ovld");
    pop_check("mt_data");

    // backpressure with a dropped beat during OUTPUT
    sb.push_back(pk_out(3, -2, 2, 0));
    start_job(1, 1);
    beat(pk_in(5, -5, 3, 0));
    wait_valid("bp_ovld");
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", out_data, sb[0]);
      check("bp_busy", busy, 1'b1);
      if (i == 2) begin
        acc_valid = 1'b1;
        acc_in = pk_in(99, 99, 99, 99);
      end
      @(negedge clk);
      acc_valid = 1'b0;
    end
    check("bp_drop", drop, 1'b1);
    check("bp_still", out_valid, 1'b1);
    pop_check("bp_data");

    // reset mid-job, then a fresh job with no residue
    start_job(4, 0);
    check("rm_dropclr", drop, 1'b0);
    beat(pk_in(30, 30, 30, 30));
    beat(pk_in(30, 30, 30, 30));
    rst = 1'b1;
    #1;
    check("rm_busy", busy, 1'b0);
    check("rm_ovld", out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sb.push_back(pk_out(7, 0, 0, 0));
    start_job(1, 0);
    beat(pk_in(7, 0, 0, 0));
    wait_valid("rm2_ovld");
    pop_check("rm2_data");

`ifdef PSUM_BIAS_EN
    sb.push_back(pk_out(6, 0, 0, 0));
    bias_in = {32'd0, 32'd0, 32'd0, 32'd16};
    start_job(1, 2);
    bias_in = '0;
    beat(pk_in(8, 0, 0, 0));
    wait_valid("b1_ovld");
    pop_check("b1_data");

    sb.push_back(pk_out(127, 0, 0, 0));
    bias_in = {32'd0, 32'd0, 32'd0, 32'd1000};
    start_job(1, 3);
    bias_in = '0;
    beat(pk_in(24, 0, 0, 0));
    wait_valid("b2_ovld");
    pop_check("b2_data");
`endif

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
